// File: rtl/mux3_port_arbiter_if.sv
// Request/grant bundle between three requesters and the shared-port arbiter.
// The lock signal exists only when MUX3_ARB_LOCK_EN is defined.
interface mux3_port_arbiter_if;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;
`ifdef MUX3_ARB_LOCK_EN
  logic       lock;
`endif

  // Requester side: drives requests/completions, observes grants.
  modport master (
    output req,
    output done,
`ifdef MUX3_ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
`ifdef MUX3_ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mux3_port_arbiter.sv
// Round-robin arbiter sharing one mux3 datapath port among three requesters,
// with a hold watchdog. Optional grant locking via MUX3_ARB_LOCK_EN.
module mux3_port_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux3_port_arbiter_if.slave   arb
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit               WD_EN   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? HOLD_MAX - 1 : 0);

  state_t           state_q;
  logic [2:0]       gnt_q;
  logic [1:0]       sel_q;
  logic [1:0]       last_q;
  logic             busy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0] winner_d;
  logic       owner_req;
  logic       owner_done;
  logic       lock_hold;
  logic       wd_hit;

  // Search starts one past the previous owner, wrapping mod 3.
  always_comb begin
    winner_d = 2'd0;
    case (last_q)
      2'd0:    winner_d = arb.req[1] ? 2'd1 : (arb.req[2] ? 2'd2 : 2'd0);
      2'd1:    winner_d = arb.req[2] ? 2'd2 : (arb.req[0] ? 2'd0 : 2'd1);
      default: winner_d = arb.req[0] ? 2'd0 : (arb.req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    owner_req  = 1'b0;
    owner_done = 1'b0;
    case (sel_q)
      2'd0:    begin owner_req = arb.req[0]; owner_done = arb.done[0]; end
      2'd1:    begin owner_req = arb.req[1]; owner_done = arb.done[1]; end
      default: begin owner_req = arb.req[2]; owner_done = arb.done[2]; end
    endcase
  end

`ifdef MUX3_ARB_LOCK_EN
  assign lock_hold = arb.lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign wd_hit = WD_EN && (cnt_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 3'b000;
      sel_q     <= 2'd0;
      last_q    <= 2'd2;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|arb.req) begin
            state_q <= BUSY;
            gnt_q   <= 3'b001 << winner_d;
            sel_q   <= winner_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          // Abort or unlocked done: normal release; done beats the watchdog.
          if (!owner_req || (owner_done && !lock_hold)) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            last_q  <= sel_q;
          end else if (owner_done) begin
            cnt_q   <= '0;
          end else if (wd_hit) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            sel_q     <= 2'd0;
            busy_q    <= 1'b0;
            last_q    <= sel_q;
            timeout_q <= 1'b1;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.sel     = sel_q;
  assign arb.busy    = busy_q;
  assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_mux3_port_arbiter.sv
// Directed self-checking bench for mux3_port_arbiter (HOLD_MAX=16).
module tb_mux3_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mux3_port_arbiter_if bus();

  mux3_port_arbiter #(.HOLD_MAX(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({tag, ".gnt"}, {1'b0, bus.gnt}, {1'b0, g});
    chk({tag, ".sel"}, {2'b00, bus.sel}, {2'b00, s});
    chk({tag, ".busy"}, {3'b000, bus.busy}, {3'b000, b});
    chk({tag, ".timeout"}, {3'b000, bus.timeout}, {3'b000, t});
  endtask

  logic [2:0] exp_gnt [7];
  logic [1:0] exp_sel [7];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req  = 3'b000;
    bus.done = 3'b000;
`ifdef MUX3_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    exp_sel = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};

    #1;
    chk_out("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_out("idle_no_req", 3'b000, 2'd0, 1'b0, 1'b0);

    // Full rotation with done asserted by every owner.
    bus.req  = 3'b111;
    bus.done = 3'b111;
    for (int i = 0; i < 7; i++) begin
      step();
      $display("rr step %0d gnt=%b sel=%0d", i, bus.gnt, bus.sel);
      chk($sformatf("rr%0d.gnt", i), {1'b0, bus.gnt}, {1'b0, exp_gnt[i]});
      chk($sformatf("rr%0d.sel", i), {2'b00, bus.sel}, {2'b00, exp_sel[i]});
    end
    bus.req  = 3'b000;
    bus.done = 3'b000;
    step();
    chk_out("abort_after_rr", 3'b000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset while requester 1 owns the port.
    bus.req = 3'b010;
    step();
    chk_out("pre_reset_own1", 3'b010, 2'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 3'b000, 2'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    bus.req = 3'b111;
    step();
    chk_out("post_reset_req0", 3'b001, 2'd0, 1'b1, 1'b0);
    bus.req = 3'b000;
    step();
    chk_out("post_reset_idle", 3'b000, 2'd0, 1'b0, 1'b0);

    // Non-owner done ignored; owner abort; pending request served next.
    bus.req = 3'b001;
    step();
    chk_out("own0", 3'b001, 2'd0, 1'b1, 1'b0);
    bus.req  = 3'b111;
    bus.done = 3'b110;
    step();
    chk_out("nonowner_done_a", 3'b001, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("nonowner_done_b", 3'b001, 2'd0, 1'b1, 1'b0);
    bus.req  = 3'b110;
    bus.done = 3'b000;
    step();
    chk_out("owner_abort", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("pending_own1", 3'b010, 2'd1, 1'b1, 1'b0);
    bus.done = 3'b010;
    step();
    chk_out("own1_done", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.done = 3'b000;
    bus.req  = 3'b010;

    // Watchdog: grant held 16 cycles, then forced release with timeout.
    step();
    chk_out("wd_grant", 3'b010, 2'd1, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("wd_hold%0d.gnt", i), {1'b0, bus.gnt}, 4'h2);
      chk($sformatf("wd_hold%0d.timeout", i), {3'b000, bus.timeout}, 4'h0);
    end
    step();
    chk_out("wd_release", 3'b000, 2'd0, 1'b0, 1'b1);

    // Re-grant after one idle cycle; done on the watchdog edge wins.
    step();
    chk_out("wd_regrant", 3'b010, 2'd1, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("wd2_hold%0d.gnt", i), {1'b0, bus.gnt}, 4'h2);
    end
    bus.done = 3'b010;
    step();
    chk_out("wd_done_edge", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.done = 3'b000;
    bus.req  = 3'b000;
    step();
    chk_out("wd_done_after", 3'b000, 2'd0, 1'b0, 1'b0);

`ifdef MUX3_ARB_LOCK_EN
    bus.req = 3'b011;
    step();
    chk_out("lock_own0", 3'b001, 2'd0, 1'b1, 1'b0);
    bus.lock = 1'b1;
    bus.done = 3'b001;
    step();
    chk_out("lock_hold", 3'b001, 2'd0, 1'b1, 1'b0);
    bus.lock = 1'b0;
    step();
    chk_out("lock_release", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.done = 3'b000;
    step();
    chk_out("lock_next_own1", 3'b010, 2'd1, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
